array_order_checker: RTL and testbench

//  Parametrised successor to the lab array sort checker. Controller and datapath are merged into one block.

---
 rtl/array_order_checker.sv | 238 +++++++++++++++++++++++
 tb/tb_array_order_checker.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/array_order_checker.sv
// Scans LENGTH words of a synchronous memory from BASE_ADDR and checks every adjacent pair against
// a selectable order, reporting sorted status, the first inverted index and the inversion count.
module array_order_checker #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDR_WIDTH    = 5,
    parameter bit SIGNED        = 1'b0,
    parameter bit STOP_ON_FIRST = 1'b1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH-1:0] length,
    input  logic                  descending,
    input  logic                  strict,
    output logic                  mem_rd_en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  busy,
    output logic                  done,
    output logic                  sorted,
    output logic                  inversion_found,
    output logic                  zero_length_array,
    output logic [ADDR_WIDTH-1:0] first_inv_index,
    output logic [ADDR_WIDTH-1:0] inv_count
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] ZERO_A = {ADDR_WIDTH{1'b0}};
    localparam logic [ADDR_WIDTH-1:0] ONE_A  = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] TWO_A  = ADDR_WIDTH'(2);

    state_t                  state_r, state_s;
    logic [ADDR_WIDTH-1:0]   len_r, len_s;
    logic                    desc_r, desc_s;
    logic                    strict_r, strict_s;
    logic                    rd_en_r, rd_en_s;
    logic [ADDR_WIDTH-1:0]   addr_r, addr_s;
    logic [ADDR_WIDTH-1:0]   rd_idx_r, rd_idx_s;
    logic                    rvalid_r, rvalid_s;
    logic [ADDR_WIDTH-1:0]   rcv_idx_r, rcv_idx_s;
    logic [DATA_WIDTH-1:0]   prev_r, prev_s;
    logic                    busy_r, busy_s;
    logic                    done_r, done_s;
    logic                    sorted_r, sorted_s;
    logic                    inv_found_r, inv_found_s;
    logic                    zero_r, zero_s;
    logic [ADDR_WIDTH-1:0]   first_idx_r, first_idx_s;
    logic [ADDR_WIDTH-1:0]   inv_cnt_r, inv_cnt_s;
    logic                    pair_inv_s;

    // Flipping the MSB maps two's complement order onto unsigned order, so one comparator serves both.
    function automatic logic is_inverted(input logic [DATA_WIDTH-1:0] p,
                                         input logic [DATA_WIDTH-1:0] c,
                                         input logic                  desc,
                                         input logic                  strict_cmp);
        logic [DATA_WIDTH-1:0] bias;
        logic                  gt;
        logic                  eq;
        bias = {SIGNED, {(DATA_WIDTH-1){1'b0}}};
        gt   = (p ^ bias) > (c ^ bias);
        eq   = (p == c);
        if (desc) begin
            is_inverted = (!gt && !eq) || (strict_cmp && eq);
        end else begin
            is_inverted = gt || (strict_cmp && eq);
        end
    endfunction

    // Inversion test for the pair (registered previous element, element arriving now).
    always_comb begin
        pair_inv_s = 1'b0;
        if (rvalid_r && (rcv_idx_r != ZERO_A)) begin
            pair_inv_s = is_inverted(prev_r, mem_rdata, desc_r, strict_r);
        end else begin
            pair_inv_s = 1'b0;
        end
    end

    // Next-state and next-output logic for the scan controller and datapath.
    always_comb begin
        state_s     = state_r;
        len_s       = len_r;
        desc_s      = desc_r;
        strict_s    = strict_r;
        rd_en_s     = rd_en_r;
        addr_s      = addr_r;
        rd_idx_s    = rd_idx_r;
        rvalid_s    = rd_en_r;
        rcv_idx_s   = rcv_idx_r;
        prev_s      = prev_r;
        done_s      = 1'b0;
        sorted_s    = sorted_r;
        inv_found_s = inv_found_r;
        zero_s      = zero_r;
        first_idx_s = first_idx_r;
        inv_cnt_s   = inv_cnt_r;

        if (((state_r == ST_SCAN) || (state_r == ST_DRAIN)) && rvalid_r) begin
            prev_s    = mem_rdata;
            rcv_idx_s = rcv_idx_r + ONE_A;
            if (pair_inv_s) begin
                inv_cnt_s   = inv_cnt_r + ONE_A;
                inv_found_s = 1'b1;
                if (!inv_found_r) begin
                    first_idx_s = rcv_idx_r;
                end else begin
                    first_idx_s = first_idx_r;
                end
            end else begin
                inv_cnt_s = inv_cnt_r;
            end
        end else begin
            prev_s = prev_r;
        end

        case (state_r)
            ST_IDLE: begin
                rd_en_s = 1'b0;
                if (start) begin
                    len_s       = length;
                    desc_s      = descending;
                    strict_s    = strict;
                    zero_s      = (length == ZERO_A);
                    sorted_s    = 1'b0;
                    inv_found_s = 1'b0;
                    first_idx_s = ZERO_A;
                    inv_cnt_s   = ZERO_A;
                    rcv_idx_s   = ZERO_A;
                    if (length < TWO_A) begin
                        state_s  = ST_DONE;
                        done_s   = 1'b1;
                        sorted_s = 1'b1;
                    end else begin
                        state_s  = ST_SCAN;
                        rd_en_s  = 1'b1;
                        addr_s   = base_addr;
                        rd_idx_s = ZERO_A;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SCAN: begin
                if (rd_idx_r == (len_r - ONE_A)) begin
                    rd_en_s = 1'b0;
                    state_s = ST_DRAIN;
                end else begin
                    rd_idx_s = rd_idx_r + ONE_A;
                    addr_s   = addr_r + ONE_A;
                end
                // Early exit: stop reading and report now; data still in flight lands in DONE and is dropped.
                if (STOP_ON_FIRST && pair_inv_s) begin
                    state_s  = ST_DONE;
                    rd_en_s  = 1'b0;
                    done_s   = 1'b1;
                    sorted_s = 1'b0;
                end else begin
                    sorted_s = sorted_r;
                end
            end
            ST_DRAIN: begin
                state_s  = ST_DONE;
                rd_en_s  = 1'b0;
                done_s   = 1'b1;
                sorted_s = !inv_found_s;
            end
            ST_DONE: begin
                state_s = ST_IDLE;
                rd_en_s = 1'b0;
            end
            default: begin
                state_s = ST_IDLE;
                rd_en_s = 1'b0;
            end
        endcase

        busy_s = (state_s != ST_IDLE);
    end

    // State and output registers; reset wins over any simultaneous start.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            len_r       <= ZERO_A;
            desc_r      <= 1'b0;
            strict_r    <= 1'b0;
            rd_en_r     <= 1'b0;
            addr_r      <= ZERO_A;
            rd_idx_r    <= ZERO_A;
            rvalid_r    <= 1'b0;
            rcv_idx_r   <= ZERO_A;
            prev_r      <= {DATA_WIDTH{1'b0}};
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            sorted_r    <= 1'b0;
            inv_found_r <= 1'b0;
            zero_r      <= 1'b0;
            first_idx_r <= ZERO_A;
            inv_cnt_r   <= ZERO_A;
        end else begin
            state_r     <= state_s;
            len_r       <= len_s;
            desc_r      <= desc_s;
            strict_r    <= strict_s;
            rd_en_r     <= rd_en_s;
            addr_r      <= addr_s;
            rd_idx_r    <= rd_idx_s;
            rvalid_r    <= rvalid_s;
            rcv_idx_r   <= rcv_idx_s;
            prev_r      <= prev_s;
            busy_r      <= busy_s;
            done_r      <= done_s;
            sorted_r    <= sorted_s;
            inv_found_r <= inv_found_s;
            zero_r      <= zero_s;
            first_idx_r <= first_idx_s;
            inv_cnt_r   <= inv_cnt_s;
        end
    end

    assign mem_rd_en         = rd_en_r;
    assign mem_addr          = addr_r;
    assign busy              = busy_r;
    assign done              = done_r;
    assign sorted            = sorted_r;
    assign inversion_found   = inv_found_r;
    assign zero_length_array = zero_r;
    assign first_inv_index   = first_idx_r;
    assign inv_count         = inv_cnt_r;

endmodule

// File: tb/tb_array_order_checker.sv
// Scoreboard bench for array_order_checker: instance A (unsigned, full scan) and instance B
// (signed, stop on first inversion) share one memory image and are checked against hand-computed results.
module tb_array_order_checker;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start_a = 1'b0, start_b = 1'b0;
    logic [4:0]  base_addr = 5'd0, length = 5'd0;
    logic        descending = 1'b0, strict = 1'b0;

    logic        rd_en_a, rd_en_b, busy_a, busy_b, done_a, done_b;
    logic [4:0]  addr_a, addr_b, fi_a, fi_b, cnt_a, cnt_b;
    logic        sorted_a, sorted_b, inv_a, inv_b, zero_a, zero_b;
    logic [31:0] rdata_a = 32'd0, rdata_b = 32'd0;
    logic [31:0] mem [32];

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct { int cyc; bit srt; bit inv; bit zero; int fi; int cnt; } exp_t;
    typedef struct { int cyc; int addr; } rd_t;
    exp_t qa[$], qb[$];
    rd_t  ra[$], rb[$];

    array_order_checker #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .SIGNED(1'b0), .STOP_ON_FIRST(1'b0)) dut_a (
        .clock(clock), .reset(reset), .start(start_a), .base_addr(base_addr), .length(length),
        .descending(descending), .strict(strict), .mem_rd_en(rd_en_a), .mem_addr(addr_a),
        .mem_rdata(rdata_a), .busy(busy_a), .done(done_a), .sorted(sorted_a),
        .inversion_found(inv_a), .zero_length_array(zero_a), .first_inv_index(fi_a), .inv_count(cnt_a));

    array_order_checker #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .SIGNED(1'b1), .STOP_ON_FIRST(1'b1)) dut_b (
        .clock(clock), .reset(reset), .start(start_b), .base_addr(base_addr), .length(length),
        .descending(descending), .strict(strict), .mem_rd_en(rd_en_b), .mem_addr(addr_b),
        .mem_rdata(rdata_b), .busy(busy_b), .done(done_b), .sorted(sorted_b),
        .inversion_found(inv_b), .zero_length_array(zero_b), .first_inv_index(fi_b), .inv_count(cnt_b));

    always #5 clock = ~clock;

    always @(posedge clock) begin
        cyc <= cyc + 1;
        if (rd_en_a) rdata_a <= mem[addr_a];
        if (rd_en_b) rdata_b <= mem[addr_b];
    end

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic cmp_done(input string tag, input exp_t e, input bit s, input bit i, input bit z,
                            input int fi, input int cnt);
        chk({tag, " done cycle"}, cyc, e.cyc);
        chk({tag, " sorted"}, s, e.srt);
        chk({tag, " inversion_found"}, i, e.inv);
        chk({tag, " zero_length_array"}, z, e.zero);
        chk({tag, " first_inv_index"}, fi, e.fi);
        chk({tag, " inv_count"}, cnt, e.cnt);
    endtask

    // Monitor: pops expected done results and read addresses whenever a DUT presents them.
    always @(negedge clock) begin
        exp_t e;
        rd_t  r;
        if (done_a) begin
            if (qa.size() == 0) chk("A unexpected done", done_a, 0);
            else begin e = qa.pop_front(); cmp_done("A", e, sorted_a, inv_a, zero_a, fi_a, cnt_a); end
        end
        if (done_b) begin
            if (qb.size() == 0) chk("B unexpected done", done_b, 0);
            else begin e = qb.pop_front(); cmp_done("B", e, sorted_b, inv_b, zero_b, fi_b, cnt_b); end
        end
        if (rd_en_a) begin
            if (ra.size() == 0) chk("A unexpected read", rd_en_a, 0);
            else begin r = ra.pop_front(); chk("A read cycle", cyc, r.cyc); chk("A read addr", addr_a, r.addr); end
        end
        if (rd_en_b) begin
            if (rb.size() == 0) chk("B unexpected read", rd_en_b, 0);
            else begin r = rb.pop_front(); chk("B read cycle", cyc, r.cyc); chk("B read addr", addr_b, r.addr); end
        end
    end

    task automatic set_mem(input int base, input int n, input int v[6]);
        for (int i = 0; i < n; i++) mem[(base + i) % 32] = v[i];
    endtask

    task automatic wait_idle(input bit b);
        int n = 0;
        do begin
            @(negedge clock);
            n++;
        end while ((b ? busy_b : busy_a) && n < 40);
        chk(b ? "B returns to idle" : "A returns to idle", b ? busy_b : busy_a, 0);
        chk(b ? "B done is a pulse" : "A done is a pulse", b ? done_b : done_a, 0);
    endtask

    // Issues one start in cycle S and queues the done result expected at S+lat and nreads reads from S+1.
    task automatic issue(input bit b, input int base, input int len, input bit desc, input bit strc,
                         input int lat, input bit srt, input bit inv, input int fi, input int cnt,
                         input int nreads);
        exp_t e;
        rd_t  r;
        @(negedge clock);
        base_addr = 5'(base); length = 5'(len); descending = desc; strict = strc;
        if (b) start_b = 1'b1; else start_a = 1'b1;
        e.cyc = cyc + lat; e.srt = srt; e.inv = inv; e.zero = (len == 0); e.fi = fi; e.cnt = cnt;
        if (b) qb.push_back(e); else qa.push_back(e);
        for (int k = 0; k < nreads; k++) begin
            r.cyc = cyc + 1 + k; r.addr = (base + k) % 32;
            if (b) rb.push_back(r); else ra.push_back(r);
        end
        @(negedge clock);
        start_a = 1'b0; start_b = 1'b0;
    endtask

    task automatic run(input bit b, input int base, input int len, input bit desc, input bit strc,
                       input int lat, input bit srt, input bit inv, input int fi, input int cnt,
                       input int nreads);
        issue(b, base, len, desc, strc, lat, srt, inv, fi, cnt, nreads);
        wait_idle(b);
    endtask

    task automatic chk_cleared(input string tag);
        chk({tag, " busy"}, busy_a, 0);      chk({tag, " done"}, done_a, 0);
        chk({tag, " mem_rd_en"}, rd_en_a, 0); chk({tag, " sorted"}, sorted_a, 0);
        chk({tag, " inversion_found"}, inv_a, 0); chk({tag, " zero_length"}, zero_a, 0);
        chk({tag, " first_inv_index"}, fi_a, 0);  chk({tag, " inv_count"}, cnt_a, 0);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = 32'd0;
        // Reset state, with a start held high against it.
        start_a = 1'b1;
        repeat (3) @(negedge clock);
        chk_cleared("reset A");
        chk("reset B busy", busy_b, 0);
        chk("reset B sorted", sorted_b, 0);
        start_a = 1'b0;
        reset = 1'b0;

        // Sorted ascending run: done at S+7, reads 11..15 on S+1..S+5.
        set_mem(11, 5, '{11, 12, 13, 14, 15, 0});
        run(0, 11, 5, 0, 0, 7, 1, 0, 0, 0, 5);
        // One inversion at k=3; full scan versus early exit.
        set_mem(2, 5, '{1, 2, 3, 2, 5, 0});
        run(0, 2, 5, 0, 0, 7, 0, 1, 3, 1, 5);
        run(1, 2, 5, 0, 0, 6, 0, 1, 3, 1, 5);
        // Reversed data: ascending finds four inversions, descending is sorted.
        set_mem(7, 5, '{11, 10, 9, 8, 7, 0});
        run(0, 7, 5, 0, 0, 7, 0, 1, 1, 4, 5);
        run(0, 7, 5, 1, 0, 7, 1, 0, 0, 0, 5);
        // First inversion index holds while later ones only bump the count.
        set_mem(16, 5, '{1, 3, 2, 5, 4, 0});
        run(0, 16, 5, 0, 0, 7, 0, 1, 2, 2, 5);
        // Short arrays: no reads, done at S+1.
        run(0, 4, 0, 0, 0, 1, 1, 0, 0, 0, 0);
        run(0, 4, 1, 0, 0, 1, 1, 0, 0, 0, 0);
        run(1, 4, 0, 0, 0, 1, 1, 0, 0, 0, 0);
        // Equal neighbours: strict decides.
        set_mem(20, 2, '{3, 3, 0, 0, 0, 0});
        run(0, 20, 2, 0, 0, 4, 1, 0, 0, 0, 2);
        run(0, 20, 2, 0, 1, 4, 0, 1, 1, 1, 2);
        run(0, 20, 2, 1, 1, 4, 0, 1, 1, 1, 2);
        // {-1,0}: sorted when signed, inverted when unsigned.
        set_mem(24, 2, '{-1, 0, 0, 0, 0, 0});
        run(1, 24, 2, 0, 0, 4, 1, 0, 0, 0, 2);
        run(0, 24, 2, 0, 0, 4, 0, 1, 1, 1, 2);
        // Descending non-strict with a tie then a rise.
        set_mem(26, 4, '{9, 9, 5, 7, 0, 0});
        run(0, 26, 4, 1, 0, 6, 0, 1, 3, 1, 4);
        // Address wrap: 30,31,0,1.
        set_mem(30, 4, '{5, 6, 7, 8, 0, 0});
        run(0, 30, 4, 0, 0, 6, 1, 0, 0, 0, 4);

        // Reset at S+3 aborts the scan: reads only S+1..S+3, no done, outputs cleared at S+4.
        begin
            rd_t r;
            @(negedge clock);
            base_addr = 5'd11; length = 5'd5; descending = 1'b0; strict = 1'b0; start_a = 1'b1;
            for (int k = 0; k < 3; k++) begin r.cyc = cyc + 1 + k; r.addr = 11 + k; ra.push_back(r); end
            @(negedge clock); start_a = 1'b0;
            @(negedge clock);
            @(negedge clock); reset = 1'b1;
            @(negedge clock); reset = 1'b0;
            chk_cleared("abort A");
            repeat (6) @(negedge clock);
            chk("abort A still idle", busy_a, 0);
        end
        // Restart completes normally.
        run(0, 11, 5, 0, 0, 7, 1, 0, 0, 0, 5);

        // A start while busy (different parameters) must not disturb the running scan.
        issue(0, 7, 5, 0, 0, 7, 0, 1, 1, 4, 5);
        base_addr = 5'd3; length = 5'd0; descending = 1'b1; start_a = 1'b1;
        @(negedge clock); start_a = 1'b0;
        wait_idle(0);

        repeat (4) @(negedge clock);
        chk("A pending done results", qa.size(), 0);
        chk("B pending done results", qb.size(), 0);
        chk("A pending reads", ra.size(), 0);
        chk("B pending reads", rb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
